regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port controller for the 64×32 three-read/one-write register file in the NN CPU. Shares the single write port between several writeback sources (ALU, load unit, NN MAC unit) using round-robin arbitration with a valid/ready handshake. Drives the register file's `writeEnable`/`wrAddr`/`wrData` from registers. Keeps a per-register busy scoreboard so that issue logic can stall reads of registers that still have writes pending.

## Interface
Parameters:
- NUM_ADDR_BITS, 6, register address width; register count is 2**NUM_ADDR_BITS
- REG_WIDTH, 32, data width
- NUM_REQ, 3, number of writeback requesters; index 0 = ALU, 1 = load, 2 = MAC

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i holds a write
- req_ready  out  NUM_REQ  grant; one-hot or zero; combinational
- req_addr  in  NUM_REQ*NUM_ADDR_BITS  destination of requester i, in slice i
- req_data  in  NUM_REQ*REG_WIDTH  data of requester i, in slice i
- scb_set_valid  in  1  issue logic reserves a destination register
- scb_set_addr  in  NUM_ADDR_BITS  register being reserved
- rdAddrA / rdAddrB / rdAddrC  in  NUM_ADDR_BITS  source addresses to check
- busyA / busyB / busyC  out  1  the matching source is busy; combinational from the scoreboard
- writeEnable  out  1  to the register file; registered
- wrAddr  out  NUM_ADDR_BITS  to the register file; registered
- wrData  out  REG_WIDTH  to the register file; registered

## Operation
- **Arbitration.**
  - rr_ptr holds the index of the last granted requester.
  - Search order is rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - req_ready[i] is high only for the first requester in that order with req_valid high.
  - A transfer occurs when req_valid[i] && req_ready[i]; at most one transfer per cycle.
  - On a transfer, rr_ptr ← i. With no transfer, rr_ptr holds.
- **Write stage.**
  - On a transfer: wrAddr ← req_addr[i], wrData ← req_data[i], writeEnable ← (req_addr[i] != 0).
  - Otherwise writeEnable ← 0; wrAddr and wrData hold.
  - Writes to r0 complete the handshake but never reach the register file.
- **Scoreboard.** busy[2**NUM_ADDR_BITS] is one bit per register.
  - Set: at posedge, if scb_set_valid and scb_set_addr != 0, busy[scb_set_addr] ← 1.
  - Clear: at posedge, if writeEnable is currently high, busy[wrAddr] ← 0.
  - Set and clear of the same address in the same cycle: set wins (a newer producer has issued).
  - Setting an already busy register leaves it busy; there is no counting. Issue logic must not reserve a busy register.
  - busy[0] is always 0.
- **Busy outputs.** busyX = busy[rdAddrX]; this is 0 when rdAddrX == 0.
- **Requester rules.**
  - A requester holds valid, addr and data stable until it is granted.
  - A requester may drop valid only after its handshake completes.

## Timing
- **Reset values (asynchronous, while rst_n = 0):**
  - writeEnable = 0, wrAddr = 0, wrData = 0
  - all busy bits = 0
  - rr_ptr = NUM_REQ-1, so requester 0 wins first
- **Write latency:**
  - Handshake in cycle N.
  - writeEnable/wrAddr/wrData are valid in cycle N+1.
  - The register file captures the write on the negedge inside cycle N+1.
  - The busy bit clears at the posedge ending cycle N+1, so busyX goes low in cycle N+2. A read in cycle N+2 sees the new data.
- **Throughput:**
  - One write per cycle, back-to-back.
  - With all requesters continuously valid, grants rotate 0,1,2,0,… and each is granted once every NUM_REQ cycles.
- **Scoreboard timing:** a reservation made in cycle N shows as busy in cycle N+1. There is no same-cycle bypass.
- **Reset mid-operation:**
  - Any pending write is dropped (writeEnable forced to 0) and busy bits clear.
  - Register file contents are not touched.
- **Two requesters, same address, consecutive cycles:** both writes occur in grant order; the last one wins.

## Structure
- Shared package `regfile_pkg` holds:
  - the NUM_ADDR_BITS, REG_WIDTH and NUM_REQ defaults
  - requester index constants REQ_ALU = 0, REQ_LOAD = 1, REQ_MAC = 2
- Sub-module `rr_arbiter`:
  - parameter NUM_REQ
  - inputs: req vector, advance strobe
  - outputs: one-hot grant, grant index
  - owns rr_ptr
- The top level holds the write-stage registers, the scoreboard and the busy muxes.

## Test plan
- **Reset:** assert rst_n = 0 mid-cycle with scoreboard bits set → outputs go to 0 immediately; after release all busyX = 0 and the first grant goes to requester 0.
- **Single write:**
  - Stimulus: reserve r5 in cycle 0; requester 1 writes r5 = 32'hDEADBEEF in cycle 3.
  - Response: busyA (rdAddrA = 5) is high in cycles 1–4; writeEnable is high in cycle 4 with wrAddr = 5; busyA is low in cycle 5.
- **Contention:** all three requesters valid for 6 cycles, targeting r1/r2/r3 → grant order 0,1,2,0,1,2; writeEnable is high on 6 consecutive cycles.
- **r0 write:** requester 2 writes r0 = 32'h1234 → req_ready pulses and writeEnable stays 0; a reservation of r0 leaves busy 0.
- **Set/clear collision:** the write to r7 reaches the write stage in the same cycle that scb_set_addr = 7 → busy[7] stays 1 afterwards.
- **Held request:** requester 0 stays valid for 3 cycles while 1 and 2 win → requester 0's addr and data are written unchanged when it is granted in the 3rd cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults and writeback source indices for the NN CPU
// register-file write path.
package regfile_pkg;

  localparam int DEF_NUM_ADDR_BITS = 6;
  localparam int DEF_REG_WIDTH     = 32;
  localparam int DEF_NUM_REQ       = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MAC  = 2;

  // Position reached by stepping forward from base, wrapping at n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last winner has highest
// priority; the pointer only moves when the caller reports a transfer.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_cand_idx;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic               w_hit;

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ and keep the first requester found.
  always_comb begin
    w_cand_idx  = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_hit       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand_idx  = IDX_W'(rr_wrap(32'(r_rr_ptr), unsigned'(k), unsigned'(NUM_REQ)));
      w_hit       = !w_found && i_req[w_cand_idx];
      w_grant_idx = w_hit ? w_cand_idx : w_grant_idx;
      w_found     = w_found || w_hit;
    end
    w_grant = w_found ? (NUM_REQ'(1'b1) << w_grant_idx) : '0;
  end

  // Last-winner pointer; reset value makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (i_advance && w_found) begin
      r_rr_ptr <= w_grant_idx;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_grant_idx;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller: arbitrates writeback sources onto the single
// register-file write port and tracks per-register pending-write status.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int REG_WIDTH     = DEF_REG_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*NUM_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]     req_data,
  input  logic                             scb_set_valid,
  input  logic [NUM_ADDR_BITS-1:0]         scb_set_addr,
  input  logic [NUM_ADDR_BITS-1:0]         rdAddrA,
  input  logic [NUM_ADDR_BITS-1:0]         rdAddrB,
  input  logic [NUM_ADDR_BITS-1:0]         rdAddrC,
  output logic                             busyA,
  output logic                             busyB,
  output logic                             busyC,
  output logic                             writeEnable,
  output logic [NUM_ADDR_BITS-1:0]         wrAddr,
  output logic [REG_WIDTH-1:0]             wrData
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 2 ** NUM_ADDR_BITS;

  logic [NUM_REQ-1:0]       w_grant;
  logic [IDX_W-1:0]         w_grant_idx;
  logic                     w_xfer;
  logic [NUM_ADDR_BITS-1:0] w_sel_addr;
  logic [REG_WIDTH-1:0]     w_sel_data;
  logic [NUM_REGS-1:0]      w_busy_nxt;

  logic                     r_we;
  logic [NUM_ADDR_BITS-1:0] r_wr_addr;
  logic [REG_WIDTH-1:0]     r_wr_data;
  logic [NUM_REGS-1:0]      r_busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req_valid),
    .i_advance   (w_xfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  // Route the winning requester's destination and data.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_grant_idx) begin
        w_sel_addr = req_addr[i*NUM_ADDR_BITS +: NUM_ADDR_BITS];
        w_sel_data = req_data[i*REG_WIDTH +: REG_WIDTH];
      end else begin
        w_sel_addr = w_sel_addr;
        w_sel_data = w_sel_data;
      end
    end
  end

  // Write stage; r0 completes the handshake but is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_xfer) begin
      r_we      <= (w_sel_addr != '0);
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
    end else begin
      r_we      <= 1'b0;
      r_wr_addr <= r_wr_addr;
      r_wr_data <= r_wr_data;
    end
  end

  // Clear on the write leaving the stage, then apply a reservation so a
  // newer producer on the same register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) begin
      w_busy_nxt[r_wr_addr] = 1'b0;
    end else begin
      w_busy_nxt[r_wr_addr] = r_busy[r_wr_addr];
    end
    if (scb_set_valid && (scb_set_addr != '0)) begin
      w_busy_nxt[scb_set_addr] = 1'b1;
    end else begin
      w_busy_nxt[scb_set_addr] = w_busy_nxt[scb_set_addr];
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busyA       = r_busy[rdAddrA];
  assign busyB       = r_busy[rdAddrB];
  assign busyC       = r_busy[rdAddrC];
  assign writeEnable = r_we;
  assign wrAddr      = r_wr_addr;
  assign wrData      = r_wr_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [17:0] req_addr;
  logic [95:0] req_data;
  logic        scb_set_valid;
  logic [5:0]  scb_set_addr;
  logic [5:0]  rdAddrA, rdAddrB, rdAddrC;
  logic        busyA, busyB, busyC;
  logic        writeEnable;
  logic [5:0]  wrAddr;
  logic [31:0] wrData;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int          m_ptr;
  bit          m_busy [64];
  bit          m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  regfile_wr_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .scb_set_valid (scb_set_valid),
    .scb_set_addr  (scb_set_addr),
    .rdAddrA       (rdAddrA),
    .rdAddrB       (rdAddrB),
    .rdAddrC       (rdAddrC),
    .busyA         (busyA),
    .busyB         (busyB),
    .busyC         (busyC),
    .writeEnable   (writeEnable),
    .wrAddr        (wrAddr),
    .wrData        (wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 2;
    m_we   = 1'b0;
    m_addr = 6'd0;
    m_data = 32'd0;
    for (int r = 0; r < 64; r++) m_busy[r] = 1'b0;
  endtask

  // Apply one posedge worth of rules to the model using current inputs.
  task automatic model_clock();
    int g;
    g = model_grant();
    if (m_we) m_busy[m_addr] = 1'b0;
    if (scb_set_valid && scb_set_addr != 6'd0) m_busy[scb_set_addr] = 1'b1;
    m_busy[0] = 1'b0;
    if (g >= 0) begin
      m_ptr  = g;
      m_addr = req_addr[g*6 +: 6];
      m_data = req_data[g*32 +: 32];
      m_we   = (m_addr != 6'd0);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*6 +: 6]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic clear_inputs();
    req_valid     = 3'b000;
    req_addr      = 18'd0;
    req_data      = 96'd0;
    scb_set_valid = 1'b0;
    scb_set_addr  = 6'd0;
    rdAddrA       = 6'd0;
    rdAddrB       = 6'd0;
    rdAddrC       = 6'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rdAddrA = 6'd5; rdAddrB = 6'd9; rdAddrC = 6'd63;
    #1;
    n_total++;
    if ({writeEnable, wrAddr, wrData, busyA, busyB, busyC} !== 42'd0)
      $display("FAIL reset_values: got we=%b addr=%0d data=%h busy=%b%b%b want all 0",
               writeEnable, wrAddr, wrData, busyA, busyB, busyC);
    else n_pass++;
    scb_set_valid = 1'b1; scb_set_addr = 6'd5;
    set_req(0, 1'b1, 6'd9, 32'hCAFE0001);
    step();
    clear_inputs();
    rdAddrA = 6'd5;
    #1;
    n_total++;
    if (busyA !== 1'b1 || writeEnable !== 1'b1)
      $display("FAIL reset_preload: got busyA=%b we=%b want 1 1", busyA, writeEnable);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (writeEnable !== 1'b0 || wrAddr !== 6'd0 || wrData !== 32'd0 || busyA !== 1'b0)
      $display("FAIL reset_async: got we=%b addr=%0d data=%h busyA=%b want 0 0 0 0",
               writeEnable, wrAddr, wrData, busyA);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 3'b111;
    #1;
    n_total++;
    if (req_ready !== 3'b001)
      $display("FAIL reset_first_grant: got %b want 001", req_ready);
    else n_pass++;
    req_valid = 3'b000;
  endtask

  task automatic test_single_write();
    do_reset();
    rdAddrA = 6'd5;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      scb_set_valid = (cyc == 0);
      scb_set_addr  = 6'd5;
      set_req(1, (cyc == 3), 6'd5, 32'hDEADBEEF);
      #1;
      n_total++;
      if (busyA !== (cyc >= 1 && cyc <= 4))
        $display("FAIL single_busyA cyc%0d: got %b want %b", cyc, busyA, (cyc >= 1 && cyc <= 4));
      else n_pass++;
      n_total++;
      if (writeEnable !== (cyc == 4))
        $display("FAIL single_we cyc%0d: got %b want %b", cyc, writeEnable, (cyc == 4));
      else n_pass++;
      if (cyc == 3) begin
        n_total++;
        if (req_ready !== 3'b010) $display("FAIL single_ready: got %b want 010", req_ready);
        else n_pass++;
      end
      if (cyc == 4) begin
        n_total++;
        if (wrAddr !== 6'd5 || wrData !== 32'hDEADBEEF)
          $display("FAIL single_wr: got addr=%0d data=%h want 5 deadbeef", wrAddr, wrData);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [31:0] d [3];
    do_reset();
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      for (int i = 0; i < 3; i++) set_req(i, (cyc < 6), 6'(i + 1), d[i]);
      #1;
      if (cyc < 6) begin
        n_total++;
        if (req_ready !== 3'(1 << (cyc % 3)))
          $display("FAIL contention_grant cyc%0d: got %b want %b", cyc, req_ready, 3'(1 << (cyc % 3)));
        else n_pass++;
      end
      n_total++;
      if (writeEnable !== (cyc >= 1 && cyc <= 6))
        $display("FAIL contention_we cyc%0d: got %b want %b", cyc, writeEnable, (cyc >= 1 && cyc <= 6));
      else n_pass++;
      if (cyc >= 1 && cyc <= 6) begin
        n_total++;
        if (wrAddr !== 6'(((cyc - 1) % 3) + 1) || wrData !== d[(cyc - 1) % 3])
          $display("FAIL contention_wr cyc%0d: got addr=%0d data=%h want %0d %h",
                   cyc, wrAddr, wrData, ((cyc - 1) % 3) + 1, d[(cyc - 1) % 3]);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_r0_write();
    do_reset();
    rdAddrA = 6'd0;
    set_req(2, 1'b1, 6'd0, 32'h1234);
    scb_set_valid = 1'b1; scb_set_addr = 6'd0;
    #1;
    n_total++;
    if (req_ready !== 3'b100) $display("FAIL r0_ready: got %b want 100", req_ready);
    else n_pass++;
    step();
    clear_inputs();
    #1;
    n_total++;
    if (writeEnable !== 1'b0 || busyA !== 1'b0 || wrData !== 32'h1234)
      $display("FAIL r0_write: got we=%b busyA=%b data=%h want 0 0 1234", writeEnable, busyA, wrData);
    else n_pass++;
    step();
  endtask

  task automatic test_collision();
    logic [31:0] d;
    d = $urandom;
    do_reset();
    rdAddrA = 6'd7;
    scb_set_valid = 1'b1; scb_set_addr = 6'd7;
    step();
    scb_set_valid = 1'b0;
    set_req(0, 1'b1, 6'd7, d);
    #1;
    n_total++;
    if (busyA !== 1'b1) $display("FAIL collision_reserved: got %b want 1", busyA);
    else n_pass++;
    step();
    set_req(0, 1'b0, 6'd0, 32'd0);
    scb_set_valid = 1'b1; scb_set_addr = 6'd7;
    #1;
    n_total++;
    if (writeEnable !== 1'b1 || wrAddr !== 6'd7 || wrData !== d)
      $display("FAIL collision_wr: got we=%b addr=%0d data=%h want 1 7 %h", writeEnable, wrAddr, wrData, d);
    else n_pass++;
    step();
    scb_set_valid = 1'b0;
    for (int cyc = 3; cyc <= 4; cyc++) begin
      #1;
      n_total++;
      if (busyA !== 1'b1) $display("FAIL collision_busy cyc%0d: got %b want 1", cyc, busyA);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_held_request();
    logic [31:0] d;
    d = $urandom;
    do_reset();
    set_req(0, 1'b1, 6'd10, 32'hA0A0A0A0);
    step();
    set_req(0, 1'b1, 6'd11, d);
    set_req(1, 1'b1, 6'd12, 32'h12121212);
    set_req(2, 1'b1, 6'd13, 32'h13131313);
    #1;
    n_total++;
    if (req_ready !== 3'b010) $display("FAIL held_grant1: got %b want 010", req_ready);
    else n_pass++;
    step();
    set_req(1, 1'b0, 6'd0, 32'd0);
    #1;
    n_total++;
    if (req_ready !== 3'b100 || wrAddr !== 6'd12)
      $display("FAIL held_grant2: got ready=%b addr=%0d want 100 12", req_ready, wrAddr);
    else n_pass++;
    step();
    set_req(2, 1'b0, 6'd0, 32'd0);
    #1;
    n_total++;
    if (req_ready !== 3'b001 || wrAddr !== 6'd13)
      $display("FAIL held_grant3: got ready=%b addr=%0d want 001 13", req_ready, wrAddr);
    else n_pass++;
    step();
    clear_inputs();
    #1;
    n_total++;
    if (writeEnable !== 1'b1 || wrAddr !== 6'd11 || wrData !== d)
      $display("FAIL held_wr: got we=%b addr=%0d data=%h want 1 11 %h", writeEnable, wrAddr, wrData, d);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    bit          pv [3];
    logic [5:0]  pa [3];
    logic [31:0] pd [3];
    int          g;
    do_reset();
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 60) begin
          pv[i] = 1'b1;
          pa[i] = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
          pd[i] = $urandom;
        end
        set_req(i, pv[i], pa[i], pd[i]);
      end
      scb_set_addr  = 6'($urandom_range(0, 63));
      scb_set_valid = ($urandom_range(0, 99) < 40) && !m_busy[scb_set_addr];
      rdAddrA = 6'($urandom_range(0, 63));
      rdAddrB = 6'($urandom_range(0, 63));
      rdAddrC = pa[$urandom_range(0, 2)];
      #1;
      g = model_grant();
      n_total++;
      if (req_ready !== ((g < 0) ? 3'b000 : 3'(1 << g)))
        $display("FAIL rand_ready cyc%0d: got %b want grant %0d", cyc, req_ready, g);
      else n_pass++;
      n_total++;
      if ({busyA, busyB, busyC} !== {m_busy[rdAddrA], m_busy[rdAddrB], m_busy[rdAddrC]})
        $display("FAIL rand_busy cyc%0d: got %b%b%b want %b%b%b", cyc, busyA, busyB, busyC,
                 m_busy[rdAddrA], m_busy[rdAddrB], m_busy[rdAddrC]);
      else n_pass++;
      n_total++;
      if (writeEnable !== m_we || wrAddr !== m_addr || wrData !== m_data)
        $display("FAIL rand_wr cyc%0d: got we=%b addr=%0d data=%h want %b %0d %h",
                 cyc, writeEnable, wrAddr, wrData, m_we, m_addr, m_data);
      else n_pass++;
      step();
      if (g >= 0) pv[g] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_contention();
    test_r0_write();
    test_collision();
    test_held_request();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
